// File: rtl/uart_ctrl.sv
// uart_ctrl: 8N1 UART transceiver with byte-wide TX/RX handshakes for the peripheral bus.
// TX bits are timed by a per-bit cycle counter; RX uses an oversampling tick divider.
module uart_ctrl #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       UART_RX,
  output logic       UART_TX,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       frame_err
);
  localparam int TICK_DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int BIT_CYC  = TICK_DIV * OVERSAMPLE;
  localparam int BCW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int TDW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OSW      = $clog2(OVERSAMPLE);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(BIT_CYC - 1);
  localparam logic [TDW-1:0] DIV_LAST = TDW'(TICK_DIV - 1);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_HALF  = OSW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  tx_state_t      r_tx_state, w_tx_state_nxt;
  logic [BCW-1:0] r_tx_cnt;
  logic [2:0]     r_tx_bit;
  logic [7:0]     r_tx_shift;
  logic           r_tx_line, w_tx_line_nxt, w_tx_busy;
  logic           w_tx_bit_end;

  assign w_tx_bit_end = (r_tx_state != TX_IDLE) && (r_tx_cnt == BIT_LAST);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge sysclk) begin
    if (reset) r_tx_state <= TX_IDLE;
    else       r_tx_state <= w_tx_state_nxt;
  end

  // NOTE: each combinational output gets a default first, so no path infers a latch.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    case (r_tx_state)
      TX_IDLE:  if (tx_start) w_tx_state_nxt = TX_START;
      TX_START: if (w_tx_bit_end) w_tx_state_nxt = TX_DATA;
      TX_DATA:  if (w_tx_bit_end && r_tx_bit == 3'd7) w_tx_state_nxt = TX_STOP;
      TX_STOP:  if (w_tx_bit_end) w_tx_state_nxt = TX_IDLE;
      default:  w_tx_state_nxt = TX_IDLE;
    endcase
  end

  // Next line level is computed here and registered, so UART_TX has no combinational path.
  always_comb begin
    w_tx_line_nxt = r_tx_line;
    w_tx_busy     = (r_tx_state != TX_IDLE);
    case (r_tx_state)
      TX_IDLE:  w_tx_line_nxt = !tx_start;
      TX_START: if (w_tx_bit_end) w_tx_line_nxt = r_tx_shift[0];
      TX_DATA:  if (w_tx_bit_end) w_tx_line_nxt = (r_tx_bit == 3'd7) ? 1'b1 : r_tx_shift[1];
      default:  w_tx_line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_line  <= 1'b1;
    end else begin
      r_tx_line <= w_tx_line_nxt;
      if (r_tx_state == TX_IDLE) begin
        r_tx_cnt <= '0;
        r_tx_bit <= '0;
        if (tx_start) r_tx_shift <= tx_data;
      end else if (w_tx_bit_end) begin
        r_tx_cnt <= '0;
        if (r_tx_state == TX_DATA) begin
          r_tx_shift <= r_tx_shift >> 1;
          r_tx_bit   <= r_tx_bit + 3'd1;
        end
      end else begin
        r_tx_cnt <= r_tx_cnt + BCW'(1);
      end
    end
  end

  assign UART_TX = r_tx_line;
  assign tx_busy = w_tx_busy;

  rx_state_t      r_rx_state, w_rx_state_nxt;
  logic           r_rx_sync1, r_rx_sync2;
  logic [TDW-1:0] r_rx_div;
  logic [OSW-1:0] r_rx_os;
  logic [2:0]     r_rx_bit;
  logic [7:0]     r_rx_shift, r_rx_data;
  logic           r_rx_valid, r_rx_overrun, r_frame_err;
  logic           w_rx_tick, w_rx_mid, w_rx_sample, w_rx_deliver, w_rx_ferr;

  assign w_rx_tick   = (r_rx_state inside {RX_START, RX_DATA, RX_STOP}) && (r_rx_div == DIV_LAST);
  assign w_rx_mid    = w_rx_tick && (r_rx_os == OS_HALF);
  assign w_rx_sample = w_rx_tick && (r_rx_os == OS_LAST);

  always_ff @(posedge sysclk) begin
    if (reset) r_rx_state <= RX_IDLE;
    else       r_rx_state <= w_rx_state_nxt;
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (!r_rx_sync2) w_rx_state_nxt = RX_START;
      RX_START: if (w_rx_mid) w_rx_state_nxt = r_rx_sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_sample && r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
      RX_STOP:  if (w_rx_sample) w_rx_state_nxt = r_rx_sync2 ? RX_IDLE : RX_WAIT;
      RX_WAIT:  if (r_rx_sync2) w_rx_state_nxt = RX_IDLE;
      default:  w_rx_state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    w_rx_deliver = 1'b0;
    w_rx_ferr    = 1'b0;
    if (r_rx_state == RX_STOP && w_rx_sample) begin
      w_rx_deliver = r_rx_sync2;
      w_rx_ferr    = !r_rx_sync2;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_rx_sync1   <= 1'b1;
      r_rx_sync2   <= 1'b1;
      r_rx_div     <= '0;
      r_rx_os      <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_sync1  <= UART_RX;
      r_rx_sync2  <= r_rx_sync1;
      r_frame_err <= w_rx_ferr;
      if (r_rx_state == RX_IDLE || r_rx_state == RX_WAIT) begin
        r_rx_div <= '0;
        r_rx_os  <= '0;
        r_rx_bit <= '0;
      end else begin
        r_rx_div <= (r_rx_div == DIV_LAST) ? '0 : r_rx_div + TDW'(1);
        if (w_rx_tick)
          r_rx_os <= ((r_rx_state == RX_START && r_rx_os == OS_HALF) || r_rx_os == OS_LAST)
                     ? '0 : r_rx_os + OSW'(1);
        if (r_rx_state == RX_DATA && w_rx_sample) begin
          r_rx_shift <= {r_rx_sync2, r_rx_shift[7:1]};
          r_rx_bit   <= r_rx_bit + 3'd1;
        end
      end
      // An ack in the delivery cycle frees the holding register for the new byte.
      if (w_rx_deliver) begin
        if (!r_rx_valid || rx_ack) begin
          r_rx_data  <= r_rx_shift;
          r_rx_valid <= 1'b1;
        end else begin
          r_rx_overrun <= 1'b1;
        end
      end else if (rx_ack && r_rx_valid) begin
        r_rx_valid   <= 1'b0;
        r_rx_overrun <= 1'b0;
      end
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign rx_overrun = r_rx_overrun;
  assign frame_err  = r_frame_err;
endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: self-checking bench for uart_ctrl at 160 kHz / 1000 baud / x16 (BIT_CYC = 160).
// Directed vectors, hand sequences for timing corners, and random frames against a byte-level model.
module tb_uart_ctrl;
  localparam int CLK_HZ  = 160_000;
  localparam int BAUD    = 1000;
  localparam int OS      = 16;
  localparam int BIT_CYC = 160;

  logic       sysclk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_drv = 1'b1;
  logic       loopback = 1'b0;
  logic       uart_rx, uart_tx;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       rx_overrun;
  logic       frame_err;

  assign uart_rx = loopback ? uart_tx : rx_drv;

  uart_ctrl #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
    .sysclk(sysclk), .reset(reset), .UART_RX(uart_rx), .UART_TX(uart_tx),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .rx_overrun(rx_overrun), .frame_err(frame_err)
  );

  always #5 sysclk = ~sysclk;

  int ferr_cnt = 0;
  always @(posedge sysclk) if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask
  task automatic chk1(input string name, input logic a, input logic e);
    check(name, 32'(a), 32'(e));
  endtask
  task automatic chk8(input string name, input logic [7:0] a, input logic [7:0] e);
    check(name, 32'(a), 32'(e));
  endtask
  task automatic chki(input string name, input int a, input int e);
    check(name, 32'(a), 32'(e));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // Called in the first busy cycle; compares 1600 cycles of line/busy against the ideal frame.
  task automatic watch_frame(input logic [7:0] d, input int inject_at, input logic hold,
                             output int bit_err, output int busy_len);
    logic [9:0] frame;
    logic [3:0] bi;
    frame = {1'b1, d, 1'b0};
    bit_err = 0;
    busy_len = 0;
    for (int k = 0; k < 10 * BIT_CYC; k++) begin
      bi = 4'(k / BIT_CYC);
      if (uart_tx !== frame[bi]) bit_err++;
      if (tx_busy === 1'b1) busy_len++;
      tx_start = hold || (k == inject_at);
      if (k == inject_at) tx_data = ~d;
      step(1);
    end
    if (!hold) begin
      tx_start = 1'b0;
      tx_data = d;
    end
  endtask

  task automatic drive_rx_frame(input logic [7:0] d, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx_drv = f[0];
      f = f >> 1;
      step(BIT_CYC);
    end
    rx_drv = 1'b1;
    step(20);
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    step(1);
    rx_ack = 1'b0;
  endtask

  task automatic wait_rx_valid(input string name);
    int waited;
    waited = 0;
    while (rx_valid !== 1'b1 && waited < 20 * BIT_CYC) begin
      step(1);
      waited++;
    end
    chk1(name, rx_valid, 1'b1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    logic       ack_after;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ovr;
    int         exp_ferr;
  } rx_vec_t;

  rx_vec_t vecs [8];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bit_err, busy_len, f0, inj;
    logic [7:0] d;
    logic good, do_ack, m_valid, m_ovr;
    logic [7:0] m_data;

    vecs[0] = '{8'hA7, 1'b1, 1'b1, 1'b1, 8'hA7, 1'b0, 0};
    vecs[1] = '{8'h81, 1'b0, 1'b0, 1'b0, 8'hA7, 1'b0, 1};
    vecs[2] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 0};
    vecs[3] = '{8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 0};
    vecs[4] = '{8'h33, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 0};
    vecs[5] = '{8'hC3, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1};
    vecs[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 0};
    vecs[7] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 0};

    // Reset state
    step(3);
    chk1("rst_tx_line", uart_tx, 1'b1);
    chk1("rst_tx_busy", tx_busy, 1'b0);
    chk1("rst_rx_valid", rx_valid, 1'b0);
    chk1("rst_rx_overrun", rx_overrun, 1'b0);
    chk1("rst_frame_err", frame_err, 1'b0);
    chk8("rst_rx_data", rx_data, 8'h00);
    reset = 1'b0;
    step(2);

    // Single A5 frame, one-cycle start pulse
    tx_data = 8'hA5;
    tx_start = 1'b1;
    step(1);
    chk1("a5_busy_first", tx_busy, 1'b1);
    chk1("a5_line_first", uart_tx, 1'b0);
    watch_frame(8'hA5, -1, 1'b0, bit_err, busy_len);
    chki("a5_bit_errors", bit_err, 0);
    chki("a5_busy_len", busy_len, 10 * BIT_CYC);
    chk1("a5_busy_after", tx_busy, 1'b0);
    chk1("a5_line_after", uart_tx, 1'b1);

    // Held start: back-to-back frames, data latched at accept
    tx_data = 8'h96;
    tx_start = 1'b1;
    step(1);
    watch_frame(8'h96, 800, 1'b1, bit_err, busy_len);
    chki("b2b_f1_bit_errors", bit_err, 0);
    chki("b2b_f1_busy_len", busy_len, 10 * BIT_CYC);
    chk1("b2b_gap_busy", tx_busy, 1'b0);
    chk1("b2b_gap_line", uart_tx, 1'b1);
    step(1);
    tx_start = 1'b0;
    chk1("b2b_f2_busy", tx_busy, 1'b1);
    chk1("b2b_f2_line", uart_tx, 1'b0);
    watch_frame(8'h69, -1, 1'b0, bit_err, busy_len);
    chki("b2b_f2_bit_errors", bit_err, 0);
    chk1("b2b_f2_busy_after", tx_busy, 1'b0);

    // Loopback 3C
    loopback = 1'b1;
    f0 = ferr_cnt;
    tx_data = 8'h3C;
    tx_start = 1'b1;
    step(1);
    watch_frame(8'h3C, -1, 1'b0, bit_err, busy_len);
    wait_rx_valid("lb_rx_valid");
    chk8("lb_rx_data", rx_data, 8'h3C);
    chki("lb_no_frame_err", ferr_cnt - f0, 0);
    pulse_ack();
    chk1("lb_ack_clears", rx_valid, 1'b0);
    loopback = 1'b0;
    step(5);

    // False start glitch, then a good 55
    f0 = ferr_cnt;
    rx_drv = 1'b0;
    step(40);
    rx_drv = 1'b1;
    step(200);
    chk1("glitch_no_valid", rx_valid, 1'b0);
    chki("glitch_no_ferr", ferr_cnt - f0, 0);
    drive_rx_frame(8'h55, 1'b1);
    chk1("after_glitch_valid", rx_valid, 1'b1);
    chk8("after_glitch_data", rx_data, 8'h55);
    pulse_ack();
    chk1("after_glitch_ack", rx_valid, 1'b0);

    // Directed RX vectors
    for (int i = 0; i < 8; i++) begin
      f0 = ferr_cnt;
      drive_rx_frame(vecs[i].data, vecs[i].stop_ok);
      chk1($sformatf("vec%0d_valid", i), rx_valid, vecs[i].exp_valid);
      chk8($sformatf("vec%0d_data", i), rx_data, vecs[i].exp_data);
      chk1($sformatf("vec%0d_overrun", i), rx_overrun, vecs[i].exp_ovr);
      chki($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
      if (vecs[i].ack_after) begin
        pulse_ack();
        chk1($sformatf("vec%0d_ack_valid", i), rx_valid, 1'b0);
        chk1($sformatf("vec%0d_ack_overrun", i), rx_overrun, 1'b0);
      end
    end

    // Random RX frames against a byte-level holding-register model
    m_valid = 1'b0;
    m_ovr = 1'b0;
    m_data = 8'h00;
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      good = ($urandom_range(3) != 0);
      do_ack = 1'($urandom_range(1));
      f0 = ferr_cnt;
      drive_rx_frame(d, good);
      if (good) begin
        if (!m_valid) begin
          m_data = d;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
      chk1($sformatf("rnd%0d_valid", i), rx_valid, m_valid);
      chk8($sformatf("rnd%0d_data", i), rx_data, m_data);
      chk1($sformatf("rnd%0d_overrun", i), rx_overrun, m_ovr);
      chki($sformatf("rnd%0d_ferr", i), ferr_cnt - f0, good ? 0 : 1);
      if (do_ack) begin
        pulse_ack();
        if (m_valid) begin
          m_valid = 1'b0;
          m_ovr = 1'b0;
        end
        chk1($sformatf("rnd%0d_ack_valid", i), rx_valid, m_valid);
        chk1($sformatf("rnd%0d_ack_overrun", i), rx_overrun, m_ovr);
      end
    end
    if (rx_valid === 1'b1) pulse_ack();

    // Random TX bytes in loopback, with an ignored start request mid-frame
    loopback = 1'b1;
    step(5);
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      inj = int'($urandom_range(1400, 50));
      tx_data = d;
      tx_start = 1'b1;
      step(1);
      watch_frame(d, inj, 1'b0, bit_err, busy_len);
      chki($sformatf("rtx%0d_bit_errors", i), bit_err, 0);
      chki($sformatf("rtx%0d_busy_len", i), busy_len, 10 * BIT_CYC);
      chk1($sformatf("rtx%0d_busy_after", i), tx_busy, 1'b0);
      wait_rx_valid($sformatf("rtx%0d_rx_valid", i));
      chk8($sformatf("rtx%0d_rx_data", i), rx_data, d);
      if (i < 3) pulse_ack();
    end

    // Reset 500 cycles into a frame, then a clean frame
    tx_data = 8'hE1;
    tx_start = 1'b1;
    step(1);
    tx_start = 1'b0;
    step(499);
    reset = 1'b1;
    step(1);
    chk1("mid_rst_line", uart_tx, 1'b1);
    chk1("mid_rst_busy", tx_busy, 1'b0);
    chk1("mid_rst_rx_valid", rx_valid, 1'b0);
    chk8("mid_rst_rx_data", rx_data, 8'h00);
    reset = 1'b0;
    step(5);
    f0 = ferr_cnt;
    tx_data = 8'h5A;
    tx_start = 1'b1;
    step(1);
    watch_frame(8'h5A, -1, 1'b0, bit_err, busy_len);
    chki("post_rst_bit_errors", bit_err, 0);
    chki("post_rst_busy_len", busy_len, 10 * BIT_CYC);
    wait_rx_valid("post_rst_rx_valid");
    chk8("post_rst_rx_data", rx_data, 8'h5A);
    chki("post_rst_no_ferr", ferr_cnt - f0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
